// File: rtl/ref_line_loader.sv
// Reference-window line loader: packs BEATS input beats into one bank-row word and
// writes it to group grp_cnt, sweeping ROWS rows per group across all GROUPS.
module ref_line_loader #(
  parameter int unsigned ROWS   = 96,
  parameter int unsigned GROUPS = 8,
  parameter int unsigned BEATS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [63:0]             in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [GROUPS*BEATS-1:0] wr_bank_sel,
  output logic [$clog2(ROWS)-1:0] wr_addr,
  output logic [64*BEATS-1:0]     wr_data,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned Banks = GROUPS * BEATS;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned RowW  = $clog2(ROWS);
  localparam int unsigned GrpW  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [BeatW-1:0] BeatLast = BeatW'(BEATS - 1);
  localparam logic [RowW-1:0]  RowLast  = RowW'(ROWS - 1);
  localparam logic [GrpW-1:0]  GrpLast  = GrpW'(GROUPS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [BeatW-1:0]           beat_cnt_q;
  logic [RowW-1:0]            row_cnt_q;
  logic [GrpW-1:0]            grp_cnt_q;
  logic [BEATS-1:0][63:0]     pack_q, pack_d;
  logic                       wr_en_q;
  logic [Banks-1:0]           sel_q, sel_d;
  logic [RowW-1:0]            addr_q;
  logic [64*BEATS-1:0]        data_q;

  logic accept, word_done, load_init;

  // Next state and per-cycle strobes
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    word_done = 1'b0;
    load_init = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          load_init = 1'b1;
        end
      end
      StLoad: begin
        accept    = in_valid;
        word_done = in_valid && (beat_cnt_q == BeatLast);
        if (word_done && (row_cnt_q == RowLast) && (grp_cnt_q == GrpLast)) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The completing beat goes straight into the output word, so the write lands one
  // cycle after the last beat without an extra pack stage.
  always_comb begin
    pack_d             = pack_q;
    pack_d[beat_cnt_q] = in_data;
  end

  always_comb begin
    sel_d = '0;
    for (int g = 0; g < int'(GROUPS); g++) begin
      if (grp_cnt_q == GrpW'(g)) begin
        sel_d[g*BEATS +: BEATS] = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      row_cnt_q  <= '0;
      grp_cnt_q  <= '0;
      pack_q     <= '0;
      wr_en_q    <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      wr_en_q <= word_done;
      if (load_init) begin
        beat_cnt_q <= '0;
        row_cnt_q  <= '0;
        grp_cnt_q  <= '0;
      end
      if (accept) begin
        pack_q     <= pack_d;
        beat_cnt_q <= (beat_cnt_q == BeatLast) ? '0 : beat_cnt_q + BeatW'(1);
      end
      if (word_done) begin
        data_q <= pack_d;
        addr_q <= row_cnt_q;
        sel_q  <= sel_d;
        if (row_cnt_q == RowLast) begin
          row_cnt_q <= '0;
          grp_cnt_q <= (grp_cnt_q == GrpLast) ? '0 : grp_cnt_q + GrpW'(1);
        end else begin
          row_cnt_q <= row_cnt_q + RowW'(1);
        end
      end
    end
  end

  assign in_ready    = (state_q == StLoad);
  assign busy        = (state_q == StLoad) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign wr_en       = wr_en_q;
  assign wr_bank_sel = sel_q;
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;

endmodule
